cell_pos_reader: RTL and testbench

//  Read-side sequencer for one per-cell position RAM (single-port, 2-cycle read latency, addr 0 = particle count).
//  On start: reads the count at addr 0, then streams addr 1..count as {posz,posy,posx} beats over valid/ready.

---
 rtl/cell_pos_reader_pkg.sv | 29 ++
 rtl/cell_pos_skid_fifo.sv | 74 +++++++
 rtl/cell_pos_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_cell_pos_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_pos_reader_pkg.sv
// Shared definitions for the cell position reader: default widths, position field
// layout inside a RAM word, FSM state encoding and FIFO entry sizing.
package cell_pos_reader_pkg;

  localparam int DATA_WIDTH_DEF = 96;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int RD_LATENCY_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int POS_FIELD_W = 32;
  localparam int POSX_LSB    = 0;
  localparam int POSY_LSB    = 32;
  localparam int POSZ_LSB    = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CNT   = 3'd1,
    ST_WAIT_CNT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // FIFO entry layout, msb first: {last, id, data}
  function automatic int entry_width(input int data_w, input int addr_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/cell_pos_skid_fifo.sv
// Small synchronous FIFO with a show-ahead head; push and pop may share a cycle.
// No bypass: a word pushed into an empty FIFO is visible on the following cycle.
module cell_pos_skid_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0] CNT_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic [PW:0]      count_nxt_s;
  logic             valid_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy and compute the next occupancy.
  always_comb begin
    do_pop_s  = pop & valid_r;
    do_push_s = push & ((count_r != FULL_C) | do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer, occupancy and non-empty flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {(PW+1){1'b0}});
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign valid     = valid_r;

endmodule

// File: rtl/cell_pos_reader.sv
// Read-side sequencer for one cell position RAM: reads the particle count at addr 0,
// then streams addr 1..count through a credit-limited skid FIFO onto valid/ready.
module cell_pos_reader
  import cell_pos_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] pos_data,
  output logic [ADDR_WIDTH-1:0] pos_id,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  pos_last,
  output logic [ADDR_WIDTH-1:0] num_particles,
  output logic                  busy,
  output logic                  done
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CRED_W-1:0]     DEPTH_C  = FIFO_DEPTH[CRED_W-1:0];
  localparam logic [CRED_W-1:0]     CRED_ONE = {{(CRED_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] ram_address_r;
  logic                  ram_rden_r;
  logic [ADDR_WIDTH-1:0] num_particles_r;
  logic                  busy_r;
  logic                  done_r;
  // Reads issued but not yet popped downstream: in flight in the RAM plus buffered.
  logic [CRED_W-1:0]     outstanding_r;
  logic [RD_LATENCY-1:0] tag_vld_r;
  logic [ADDR_WIDTH-1:0] tag_addr_r [RD_LATENCY];

  logic                  pop_s;
  logic                  push_s;
  logic                  cnt_ret_s;
  logic                  credit_ok_s;
  logic                  issue_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic [ADDR_WIDTH-1:0] ret_addr_s;
  logic [ADDR_WIDTH-1:0] cnt_val_s;
  logic [ENTRY_W-1:0]    push_entry_s;
  logic [ENTRY_W-1:0]    head_entry_s;
  logic                  fifo_valid_s;

  // Classify the returning RAM word and decide whether a read issues this cycle.
  always_comb begin
    pop_s        = fifo_valid_s & pos_ready;
    ret_addr_s   = tag_addr_r[RD_LATENCY-1];
    cnt_val_s    = ram_q[ADDR_WIDTH-1:0];
    cnt_ret_s    = tag_vld_r[RD_LATENCY-1] & (ret_addr_s == ADDR_ZERO);
    push_s       = tag_vld_r[RD_LATENCY-1] & (ret_addr_s != ADDR_ZERO);
    push_entry_s = {(ret_addr_s == num_particles_r), ret_addr_s, ram_q};
    // A pop in this cycle frees its slot in time for the read issued at this edge.
    credit_ok_s  = (outstanding_r < DEPTH_C) | pop_s;
    issue_s      = 1'b0;
    issue_addr_s = addr_r;
    case (state_r)
      ST_WAIT_CNT: begin
        issue_s      = cnt_ret_s & (cnt_val_s != ADDR_ZERO);
        issue_addr_s = ADDR_ONE;
      end
      ST_STREAM: begin
        issue_s      = credit_ok_s;
        issue_addr_s = addr_r;
      end
      default: begin
        issue_s      = 1'b0;
        issue_addr_s = addr_r;
      end
    endcase
  end

  // Sequencer: count read, data read issue, drain and done handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      addr_r          <= ADDR_ZERO;
      ram_address_r   <= ADDR_ZERO;
      ram_rden_r      <= 1'b0;
      num_particles_r <= ADDR_ZERO;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r       <= ST_RD_CNT;
            busy_r        <= 1'b1;
            ram_rden_r    <= 1'b1;
            ram_address_r <= ADDR_ZERO;
          end else begin
            ram_rden_r <= 1'b0;
          end
        end
        ST_RD_CNT: begin
          ram_rden_r <= 1'b0;
          state_r    <= ST_WAIT_CNT;
        end
        ST_WAIT_CNT: begin
          ram_rden_r <= issue_s;
          if (cnt_ret_s) begin
            num_particles_r <= cnt_val_s;
            if (cnt_val_s == ADDR_ZERO) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              ram_address_r <= issue_addr_s;
              addr_r        <= ADDR_TWO;
              state_r       <= (cnt_val_s == ADDR_ONE) ? ST_DRAIN : ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          ram_rden_r <= issue_s;
          if (issue_s) begin
            ram_address_r <= issue_addr_s;
            // Address saturates at the count; the final read hands over to DRAIN.
            if (addr_r == num_particles_r) begin
              state_r <= ST_DRAIN;
            end else begin
              addr_r <= addr_r + ADDR_ONE;
            end
          end
        end
        ST_DRAIN: begin
          ram_rden_r <= 1'b0;
          if ((outstanding_r == {CRED_W{1'b0}}) ||
              ((outstanding_r == CRED_ONE) && pop_s)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          ram_rden_r <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          ram_rden_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Credit counter: +1 per data read issued, -1 per beat accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= {CRED_W{1'b0}};
    end else begin
      case ({issue_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + CRED_ONE;
        2'b01:   outstanding_r <= outstanding_r - CRED_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Read tag pipeline; the last stage lines up with the RAM output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_addr_r[i] <= ADDR_ZERO;
      end
    end else begin
      tag_vld_r[0]  <= ram_rden_r;
      tag_addr_r[0] <= ram_address_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_r[i]  <= tag_vld_r[i-1];
        tag_addr_r[i] <= tag_addr_r[i-1];
      end
    end
  end

  cell_pos_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .valid     (fifo_valid_s)
  );

  assign ram_address   = ram_address_r;
  assign ram_rden      = ram_rden_r;
  assign ram_wren      = 1'b0;
  assign ram_data      = {DATA_WIDTH{1'b0}};
  assign pos_data      = head_entry_s[DATA_WIDTH-1:0];
  assign pos_id        = head_entry_s[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
  assign pos_last      = head_entry_s[ENTRY_W-1];
  assign pos_valid     = fifo_valid_s;
  assign num_particles = num_particles_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_cell_pos_reader.sv
// Scoreboard bench for cell_pos_reader with a 2-cycle-latency preloaded RAM model.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] id;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] ram_address;
  logic          ram_rden;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] pos_data;
  logic [AW-1:0] pos_id;
  logic          pos_valid;
  logic          pos_ready;
  logic          pos_last;
  logic [AW-1:0] num_particles;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] st1 = '0;
  exp_t          sb_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  bit rdy_rand = 1'b0;

  int beats, done_cnt, first_valid, first_xfer, last_xfer, done_cyc;
  int addr0_reads, rd_cnt, pop_cnt, max_occ;
  bit saw_valid, wr_bad, hold_pend, busy_pre_done, prev_busy;
  logic [DW+AW:0] hold_vec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cell_pos_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ram_address   (ram_address),
    .ram_rden      (ram_rden),
    .ram_wren      (ram_wren),
    .ram_data      (ram_data),
    .ram_q         (ram_q),
    .pos_data      (pos_data),
    .pos_id        (pos_id),
    .pos_valid     (pos_valid),
    .pos_ready     (pos_ready),
    .pos_last      (pos_last),
    .num_particles (num_particles),
    .busy          (busy),
    .done          (done)
  );

  // RAM model: address registered on the rden edge, data out one edge later.
  always @(posedge clk) begin
    if (ram_rden) st1 <= mem[ram_address];
    ram_q <= st1;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) pos_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    beats = 0; done_cnt = 0; first_valid = -1; first_xfer = -1; last_xfer = 0;
    done_cyc = 0; addr0_reads = 0; rd_cnt = 0; pop_cnt = 0; max_occ = 0;
    saw_valid = 0; wr_bad = 0; hold_pend = 0; busy_pre_done = 0;
  endtask

  // Monitor: pops the scoreboard on every accepted beat and tracks protocol facts.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
      prev_busy = 0;
    end else begin
      if (ram_wren !== 1'b0 || ram_data !== '0) wr_bad = 1;
      if (ram_rden && ram_address == '0) addr0_reads++;
      if (ram_rden && ram_address != '0) rd_cnt++;
      if (rd_cnt - pop_cnt > max_occ) max_occ = rd_cnt - pop_cnt;
      if (hold_pend) chk("held_stable", {pos_valid, pos_last, pos_id, pos_data}, {1'b1, hold_vec});
      hold_pend = pos_valid && !pos_ready;
      hold_vec  = {pos_last, pos_id, pos_data};
      if (pos_valid && !saw_valid) begin
        saw_valid   = 1;
        first_valid = cyc - t_start;
      end
      if (pos_valid && pos_ready) begin
        exp_t e;
        pop_cnt++;
        beats++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", {pos_id, pos_data}, '0);
        end else begin
          e = sb_q.pop_front();
          chk("beat_data", pos_data, e.data);
          chk("beat_id", pos_id, e.id);
          chk("beat_last", pos_last, e.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc      = cyc;
        busy_pre_done = prev_busy;
        chk("busy_low_in_done", busy, 1'b0);
      end
      prev_busy = busy;
    end
  end

  task automatic preload(input int cnt);
    logic [DW-1:0] w;
    exp_t e;
    w = {$urandom, $urandom, $urandom};
    w[AW-1:0] = cnt[AW-1:0];
    mem[0] = w;
    for (int i = 1; i <= cnt; i++) begin
      mem[i] = {$urandom, $urandom, $urandom};
      e.data = mem[i];
      e.id   = i[AW-1:0];
      e.last = (i == cnt);
      sb_q.push_back(e);
    end
    clear_stats();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    t_start = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_txn(input int cnt, input bit rnd, input bit restart);
    int n;
    preload(cnt);
    rdy_rand = rnd;
    if (!rnd) pos_ready = 1'b1;
    pulse_start();
    if (restart) begin
      repeat (9) @(posedge clk);
      #1;
      chk("busy_at_restart", busy, 1'b1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", n < 3000, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rdy_rand = 1'b0;
    pos_ready = 1'b1;
    chk("beats", beats, cnt);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("num_particles", num_particles, cnt[AW-1:0]);
    chk("addr0_reads", addr0_reads, 1);
    chk("credit_bound", max_occ <= 4, 1'b1);
    chk("busy_before_done", busy_pre_done, 1'b1);
    chk("ram_write_idle", wr_bad, 1'b0);
    chk("busy_idle_after", busy, 1'b0);
    if (cnt == 0) begin
      chk("cnt0_no_valid", saw_valid, 1'b0);
      chk("cnt0_done_latency", (done_cyc - t_start) <= 6, 1'b1);
    end else begin
      chk("done_after_last", done_cyc - last_xfer, 1);
    end
    if (cnt == 3) begin
      chk("first_valid_cycle", first_valid, 7);
      chk("ids_consecutive", last_xfer - first_xfer, 2);
    end
    if (cnt == 255) chk("no_bubbles", last_xfer - first_xfer, 254);
    sb_q.delete();
  endtask

  task automatic reset_test();
    int n;
    preload(10);
    pos_ready = 1'b1;
    pulse_start();
    n = 0;
    while (beats < 5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reset_wait_timeout", n < 200, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("outputs_zero_in_reset",
        {pos_valid, pos_last, pos_id, pos_data, busy, done, ram_rden, ram_address,
         num_particles, ram_wren}, '0);
    sb_q.delete();
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_beat_after_reset", beats, 0);
    chk("no_done_after_reset", done_cnt, 0);
    run_txn(10, 1'b1, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pos_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {pos_valid, pos_last, pos_id, pos_data, busy, done, ram_rden, ram_address,
         num_particles, ram_wren}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_txn(3, 1'b0, 1'b0);
    run_txn(0, 1'b0, 1'b0);
    run_txn(16, 1'b1, 1'b0);
    run_txn(255, 1'b0, 1'b0);
    run_txn(8, 1'b0, 1'b1);
    reset_test();
    for (int k = 0; k < 3; k++) run_txn(int'($urandom_range(1, 40)), 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
